// File: rtl/pong_game_engine.sv
`timescale 1ns/1ps
// pong_game_engine: frame-rate Pong game state (ball, paddles, BCD scores,
// serve/pause/game-over sequencing). All state advances on frame_tick or serve.
// Ports:
//   clk, reset (sync, active-high)      clock and reset
//   frame_tick                          one-cycle pulse per displayed frame
//   l_up/l_down/r_up/r_down, serve      button levels
//   ball_x/ball_y, paddle_l_y/_r_y      registered positions (top-left)
//   ball_width, paddle_*_x/_width/_len  geometry constants for the renderer
//   score_*_tens/_ones                  registered BCD scores
//   game_over                           registered, high in OVER
module pong_game_engine #(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned BALL_W       = 8,
    parameter int unsigned PADDLE_W     = 8,
    parameter int unsigned PADDLE_LEN   = 64,
    parameter int unsigned PADDLE_L_X   = 20,
    parameter int unsigned PADDLE_R_X   = 612,
    parameter int unsigned PADDLE_STEP  = 4,
    parameter int unsigned BALL_DX      = 2,
    parameter int unsigned BALL_DY      = 2,
    parameter int unsigned WIN_SCORE    = 11,
    parameter int unsigned PAUSE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       l_up,
    input  logic       l_down,
    input  logic       r_up,
    input  logic       r_down,
    input  logic       serve,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [5:0] ball_width,
    output logic [9:0] paddle_l_x,
    output logic [9:0] paddle_r_x,
    output logic [8:0] paddle_l_y,
    output logic [8:0] paddle_r_y,
    output logic [5:0] paddle_width,
    output logic [8:0] paddle_length,
    output logic [3:0] score_left_tens,
    output logic [3:0] score_left_ones,
    output logic [3:0] score_right_tens,
    output logic [3:0] score_right_ones,
    output logic       game_over
);

    localparam int unsigned BALL_X0    = (SCREEN_W - BALL_W) / 2;
    localparam int unsigned BALL_Y0    = (SCREEN_H - BALL_W) / 2;
    localparam int unsigned PAD_Y0     = (SCREEN_H - PADDLE_LEN) / 2;
    localparam int unsigned PAD_Y_MAX  = SCREEN_H - PADDLE_LEN;
    localparam int unsigned BALL_Y_MAX = SCREEN_H - BALL_W;
    localparam int unsigned L_FACE     = PADDLE_L_X + PADDLE_W;
    localparam int unsigned CNT_W      = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_OVER} state_e;

    state_e           state_q, state_d;
    logic [9:0]       ball_x_q, ball_x_d;
    logic [8:0]       ball_y_q, ball_y_d;
    logic             dx_neg_q, dx_neg_d;
    logic             dy_neg_q, dy_neg_d;
    logic [8:0]       pad_l_y_q, pad_l_y_d;
    logic [8:0]       pad_r_y_q, pad_r_y_d;
    logic [7:0]       score_l_q, score_l_d;   // {tens, ones}
    logic [7:0]       score_r_q, score_r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             game_over_q, game_over_d;

    logic [10:0] bx, by, pl, pr;
    logic        ovl_l, ovl_r, hit_l, hit_r, left_scores, right_scores;
    logic [7:0]  score_l_inc, score_r_inc;

    // Move a paddle one step, clamped to the playfield; opposing buttons cancel.
    function automatic logic [8:0] paddle_next(input logic [8:0] y, input logic up, input logic dn);
        logic [10:0] y_w;
        y_w = {2'b00, y};
        if (up && !dn) begin
            y_w = (y_w < 11'(PADDLE_STEP)) ? 11'd0 : y_w - 11'(PADDLE_STEP);
        end else if (dn && !up) begin
            y_w = (y_w + 11'(PADDLE_STEP) > 11'(PAD_Y_MAX)) ? 11'(PAD_Y_MAX) : y_w + 11'(PADDLE_STEP);
        end
        return 9'(y_w);
    endfunction

    // Saturating two-digit BCD increment.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99) return s;
        if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
        return {s[7:4], s[3:0] + 4'd1};
    endfunction

    function automatic logic bcd_is_win(input logic [7:0] s);
        logic [7:0] v;
        v = 8'(s[7:4]) * 8'd10 + 8'(s[3:0]);
        return v == 8'(WIN_SCORE);
    endfunction

    // Collision and miss decode from pre-tick ball and paddle positions.
    assign bx    = 11'(ball_x_q);
    assign by    = 11'(ball_y_q);
    assign pl    = 11'(pad_l_y_q);
    assign pr    = 11'(pad_r_y_q);
    assign ovl_l = (by + 11'(BALL_W) > pl) && (by < pl + 11'(PADDLE_LEN));
    assign ovl_r = (by + 11'(BALL_W) > pr) && (by < pr + 11'(PADDLE_LEN));
    assign hit_r = !dx_neg_q && (bx + 11'(BALL_W) <= 11'(PADDLE_R_X))
                   && (bx + 11'(BALL_W) + 11'(BALL_DX) >= 11'(PADDLE_R_X)) && ovl_r;
    assign hit_l = dx_neg_q && (bx >= 11'(L_FACE)) && (bx <= 11'(L_FACE) + 11'(BALL_DX)) && ovl_l;
    assign left_scores  = !dx_neg_q && (bx + 11'(BALL_W) + 11'(BALL_DX) > 11'(SCREEN_W));
    assign right_scores = dx_neg_q && (bx < 11'(BALL_DX));
    assign score_l_inc  = bcd_inc(score_l_q);
    assign score_r_inc  = bcd_inc(score_r_q);

    // Next-state logic for the game FSM and all game state.
    always_comb begin
        state_d   = state_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        dx_neg_d  = dx_neg_q;
        dy_neg_d  = dy_neg_q;
        pad_l_y_d = pad_l_y_q;
        pad_r_y_d = pad_r_y_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        cnt_d     = cnt_q;

        if (frame_tick && (state_q != S_OVER)) begin
            pad_l_y_d = paddle_next(pad_l_y_q, l_up, l_down);
            pad_r_y_d = paddle_next(pad_r_y_q, r_up, r_down);
        end

        case (state_q)
            S_IDLE: begin
                if (serve) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (frame_tick) begin
                    if (dy_neg_q) begin
                        if (by < 11'(BALL_DY)) begin
                            ball_y_d = 9'd0;
                            dy_neg_d = 1'b0;
                        end else begin
                            ball_y_d = ball_y_q - 9'(BALL_DY);
                        end
                    end else if (by + 11'(BALL_W) + 11'(BALL_DY) > 11'(SCREEN_H)) begin
                        ball_y_d = 9'(BALL_Y_MAX);
                        dy_neg_d = 1'b1;
                    end else begin
                        ball_y_d = ball_y_q + 9'(BALL_DY);
                    end

                    // A miss recenters the ball (overriding the vertical move) and
                    // serves toward the player who conceded.
                    if (hit_r) begin
                        ball_x_d = 10'(PADDLE_R_X - BALL_W);
                        dx_neg_d = 1'b1;
                    end else if (hit_l) begin
                        ball_x_d = 10'(L_FACE);
                        dx_neg_d = 1'b0;
                    end else if (left_scores) begin
                        score_l_d = score_l_inc;
                        dx_neg_d  = 1'b0;
                        ball_x_d  = 10'(BALL_X0);
                        ball_y_d  = 9'(BALL_Y0);
                        cnt_d     = '0;
                        state_d   = bcd_is_win(score_l_inc) ? S_OVER : S_PAUSE;
                    end else if (right_scores) begin
                        score_r_d = score_r_inc;
                        dx_neg_d  = 1'b1;
                        ball_x_d  = 10'(BALL_X0);
                        ball_y_d  = 9'(BALL_Y0);
                        cnt_d     = '0;
                        state_d   = bcd_is_win(score_r_inc) ? S_OVER : S_PAUSE;
                    end else begin
                        ball_x_d = dx_neg_q ? ball_x_q - 10'(BALL_DX) : ball_x_q + 10'(BALL_DX);
                    end
                end
            end
            S_PAUSE: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_W'(PAUSE_FRAMES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_PLAY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_OVER: begin
                if (serve) begin
                    state_d   = S_IDLE;
                    ball_x_d  = 10'(BALL_X0);
                    ball_y_d  = 9'(BALL_Y0);
                    dx_neg_d  = 1'b0;
                    dy_neg_d  = 1'b0;
                    pad_l_y_d = 9'(PAD_Y0);
                    pad_r_y_d = 9'(PAD_Y0);
                    score_l_d = 8'h00;
                    score_r_d = 8'h00;
                    cnt_d     = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        game_over_d = (state_d == S_OVER);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ball_x_q    <= 10'(BALL_X0);
            ball_y_q    <= 9'(BALL_Y0);
            dx_neg_q    <= 1'b0;
            dy_neg_q    <= 1'b0;
            pad_l_y_q   <= 9'(PAD_Y0);
            pad_r_y_q   <= 9'(PAD_Y0);
            score_l_q   <= 8'h00;
            score_r_q   <= 8'h00;
            cnt_q       <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_neg_q    <= dx_neg_d;
            dy_neg_q    <= dy_neg_d;
            pad_l_y_q   <= pad_l_y_d;
            pad_r_y_q   <= pad_r_y_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            cnt_q       <= cnt_d;
            game_over_q <= game_over_d;
        end
    end

    assign ball_x           = ball_x_q;
    assign ball_y           = ball_y_q;
    assign paddle_l_y       = pad_l_y_q;
    assign paddle_r_y       = pad_r_y_q;
    assign score_left_tens  = score_l_q[7:4];
    assign score_left_ones  = score_l_q[3:0];
    assign score_right_tens = score_r_q[7:4];
    assign score_right_ones = score_r_q[3:0];
    assign game_over        = game_over_q;
    assign ball_width       = 6'(BALL_W);
    assign paddle_l_x       = 10'(PADDLE_L_X);
    assign paddle_r_x       = 10'(PADDLE_R_X);
    assign paddle_width     = 6'(PADDLE_W);
    assign paddle_length    = 9'(PADDLE_LEN);

endmodule

// File: tb/tb_pong_game_engine.sv
`timescale 1ns/1ps
// tb_pong_game_engine: directed and randomized stimulus for pong_game_engine,
// checked every cycle against an integer-arithmetic model of the game rules.
module tb_pong_game_engine;

    localparam int SW = 640, SH = 480, BW = 8, PW = 8, PLEN = 64;
    localparam int LX = 20, RX = 612, STEP = 4, DX = 2, DY = 2;
    localparam int WIN = 11, PF = 60;
    localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_OVER = 3;

    logic       clk = 1'b0;
    logic       reset, frame_tick, l_up, l_down, r_up, r_down, serve;
    logic [9:0] ball_x, paddle_l_x, paddle_r_x;
    logic [8:0] ball_y, paddle_l_y, paddle_r_y, paddle_length;
    logic [5:0] ball_width, paddle_width;
    logic [3:0] score_left_tens, score_left_ones, score_right_tens, score_right_ones;
    logic       game_over;

    always #5 clk = ~clk;

    pong_game_engine #(
        .SCREEN_W(SW), .SCREEN_H(SH), .BALL_W(BW), .PADDLE_W(PW), .PADDLE_LEN(PLEN),
        .PADDLE_L_X(LX), .PADDLE_R_X(RX), .PADDLE_STEP(STEP), .BALL_DX(DX), .BALL_DY(DY),
        .WIN_SCORE(WIN), .PAUSE_FRAMES(PF)
    ) u_dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .l_up(l_up), .l_down(l_down), .r_up(r_up), .r_down(r_down), .serve(serve),
        .ball_x(ball_x), .ball_y(ball_y), .ball_width(ball_width),
        .paddle_l_x(paddle_l_x), .paddle_r_x(paddle_r_x),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .paddle_width(paddle_width), .paddle_length(paddle_length),
        .score_left_tens(score_left_tens), .score_left_ones(score_left_ones),
        .score_right_tens(score_right_tens), .score_right_ones(score_right_ones),
        .game_over(game_over)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain integers, signed velocities, decimal scores.
    int m_mode, m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_pc;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic bit overlaps(input int by, input int py);
        return (by + BW > py) && (by < py + PLEN);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_bx = (SW - BW) / 2; m_by = (SH - BW) / 2;
        m_dx = 1; m_dy = 1; m_pl = (SH - PLEN) / 2; m_pr = (SH - PLEN) / 2;
        m_sl = 0; m_sr = 0; m_pc = 0;
    endtask

    task automatic model_point(input bit left);
        int s;
        if (left) begin m_sl = (m_sl < 99) ? m_sl + 1 : 99; s = m_sl; m_dx = 1; end
        else      begin m_sr = (m_sr < 99) ? m_sr + 1 : 99; s = m_sr; m_dx = -1; end
        m_bx = (SW - BW) / 2; m_by = (SH - BW) / 2; m_pc = 0;
        m_mode = (s == WIN) ? M_OVER : M_PAUSE;
    endtask

    task automatic model_step(input bit rst, input bit tick, input bit lu, input bit ld,
                              input bit ru, input bit rd, input bit srv);
        int opl, opr, oby, nx, ny;
        if (rst) begin model_reset(); return; end
        opl = m_pl; opr = m_pr; oby = m_by;
        if (tick && m_mode != M_OVER) begin
            m_pl = clampi(m_pl + STEP * (int'(ld) - int'(lu)), 0, SH - PLEN);
            m_pr = clampi(m_pr + STEP * (int'(rd) - int'(ru)), 0, SH - PLEN);
        end
        case (m_mode)
            M_IDLE: if (srv) m_mode = M_PLAY;
            M_PLAY: if (tick) begin
                ny = m_by + m_dy * DY;
                if (ny < 0)            begin m_by = 0;       m_dy = 1;  end
                else if (ny > SH - BW) begin m_by = SH - BW; m_dy = -1; end
                else m_by = ny;
                nx = m_bx + m_dx * DX;
                if (m_dx > 0 && m_bx + BW <= RX && nx + BW >= RX && overlaps(oby, opr)) begin
                    m_bx = RX - BW; m_dx = -1;
                end else if (m_dx < 0 && m_bx >= LX + PW && nx <= LX + PW && overlaps(oby, opl)) begin
                    m_bx = LX + PW; m_dx = 1;
                end else if (nx + BW > SW) model_point(1'b1);
                else if (nx < 0)           model_point(1'b0);
                else m_bx = nx;
            end
            M_PAUSE: if (tick) begin
                m_pc++;
                if (m_pc == PF) begin m_pc = 0; m_mode = M_PLAY; end
            end
            default: if (srv) model_reset();
        endcase
    endtask

    task automatic check_all();
        chk("ball_x", int'(ball_x), m_bx);
        chk("ball_y", int'(ball_y), m_by);
        chk("paddle_l_y", int'(paddle_l_y), m_pl);
        chk("paddle_r_y", int'(paddle_r_y), m_pr);
        chk("score_l_tens", int'(score_left_tens), m_sl / 10);
        chk("score_l_ones", int'(score_left_ones), m_sl % 10);
        chk("score_r_tens", int'(score_right_tens), m_sr / 10);
        chk("score_r_ones", int'(score_right_ones), m_sr % 10);
        chk("game_over", int'(game_over), int'(m_mode == M_OVER));
    endtask

    // One clock: drive, advance the model at the edge, sample 1ns later.
    task automatic cyc(input bit rst, input bit tick, input bit lu, input bit ld,
                       input bit ru, input bit rd, input bit srv);
        reset = rst; frame_tick = tick; l_up = lu; l_down = ld;
        r_up = ru; r_down = rd; serve = srv;
        @(posedge clk);
        model_step(rst, tick, lu, ld, ru, rd, srv);
        #1;
        check_all();
    endtask

    task automatic frame(input bit lu, input bit ld, input bit ru, input bit rd);
        cyc(1'b0, 1'b1, lu, ld, ru, rd, 1'b0);
        cyc(1'b0, 1'b0, lu, ld, ru, rd, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        bit ru, rd, seen10, rst_r, tick_r, srv_r;
        int gap;

        // Reset values and geometry constants.
        do_reset();
        chk("rst_ball_x", int'(ball_x), 316);
        chk("rst_ball_y", int'(ball_y), 236);
        chk("rst_pad_l", int'(paddle_l_y), 208);
        chk("rst_pad_r", int'(paddle_r_y), 208);
        chk("rst_go", int'(game_over), 0);
        chk("ball_width", int'(ball_width), 8);
        chk("paddle_l_x", int'(paddle_l_x), 20);
        chk("paddle_r_x", int'(paddle_r_x), 612);
        chk("paddle_width", int'(paddle_width), 8);
        chk("paddle_length", int'(paddle_length), 64);

        // Idle ticks leave the ball alone; serve then bounce off the bottom and miss.
        for (int t = 0; t < 10; t++) frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_ball_x", int'(ball_x), 316);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= 159; t++) begin
            frame(1'b0, 1'b0, 1'b0, 1'b0);
            if (t == 1)   begin chk("t1_x", int'(ball_x), 318); chk("t1_y", int'(ball_y), 238); end
            if (t == 118) chk("t118_y", int'(ball_y), 472);
            if (t == 119) chk("t119_y", int'(ball_y), 472);
            if (t == 120) chk("t120_y", int'(ball_y), 470);
        end
        chk("miss_sl_ones", int'(score_left_ones), 1);
        chk("miss_x", int'(ball_x), 316);
        chk("miss_y", int'(ball_y), 236);
        for (int t = 0; t < PF; t++) frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pause_x", int'(ball_x), 316);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk("resume_x", int'(ball_x), 318);

        // Right paddle clamps at the bottom and returns the ball.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= 145; t++) begin
            frame(1'b0, 1'b0, 1'b0, 1'b1);
            if (t == 52)  chk("pad_r_clamp", int'(paddle_r_y), 416);
            if (t == 144) chk("hit_r_x", int'(ball_x), 604);
            if (t == 145) chk("after_hit_x", int'(ball_x), 602);
        end

        // Opposing buttons cancel; up clamps at 0.
        do_reset();
        for (int t = 0; t < 5; t++) frame(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pad_l_both", int'(paddle_l_y), 208);
        for (int t = 0; t < 60; t++) frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pad_l_top", int'(paddle_l_y), 0);

        // Right paddle dodges every serve, so left wins 11-0.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        seen10 = 1'b0;
        for (int t = 0; t < 4000 && m_mode != M_OVER; t++) begin
            ru = (m_by + BW / 2 > SH / 2);
            rd = !ru;
            frame(1'b0, 1'b0, ru, rd);
            if (m_sl == 10 && !seen10) begin
                seen10 = 1'b1;
                chk("ten_tens", int'(score_left_tens), 1);
                chk("ten_ones", int'(score_left_ones), 0);
            end
        end
        chk("win_go", int'(game_over), 1);
        chk("win_tens", int'(score_left_tens), 1);
        chk("win_ones", int'(score_left_ones), 1);
        for (int t = 0; t < 5; t++) frame(1'b1, 1'b0, 1'b0, 1'b1);
        chk("over_ball_x", int'(ball_x), 316);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("restart_go", int'(game_over), 0);
        chk("restart_sl", int'(score_left_ones), 0);
        chk("restart_pad_r", int'(paddle_r_y), 208);

        // Randomized play with occasional serves, mid-frame resets and variable gaps.
        do_reset();
        for (int f = 0; f < 6000; f++) begin
            rst_r  = ($urandom_range(0, 1999) == 0);
            tick_r = ($urandom_range(0, 7) != 0);
            srv_r  = ($urandom_range(0, 15) == 0);
            cyc(rst_r, tick_r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), srv_r);
            gap = int'($urandom_range(1, 3));
            for (int g = 0; g < gap; g++)
                cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ($urandom_range(0, 31) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
